// File: rtl/gcd_dispatch_if.sv
// gcd_dispatch_if: job, core and result handshake bundle for gcd_dispatch
interface gcd_dispatch_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             gcd_start;
  logic [WIDTH-1:0] gcd_a;
  logic [WIDTH-1:0] gcd_b;
  logic [WIDTH-1:0] gcd_result;
  logic             gcd_done;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_tag;
  logic             out_err;
  logic             busy;
  modport slave (
    input  in_valid, in_a, in_b, gcd_result, gcd_done, out_ready,
    output in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_result, out_tag, out_err, busy
  );
  modport master (
    output in_valid, in_a, in_b, gcd_result, gcd_done, out_ready,
    input  in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_result, out_tag, out_err, busy
  );
endinterface

// File: rtl/gcd_dispatch.sv
// gcd_dispatch: queues GCD jobs and dispatches them one at a time to a gcd core with timeout
module gcd_dispatch #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input logic           clk,
  input logic           reset,
  gcd_dispatch_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [3:0]       mem_tag [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [3:0]       push_tag, cur_tag;
  logic [CW-1:0]    cnt;
  logic             push, pop, start_job, capture, expire, release_out;
  assign bus.in_ready  = count != (AW+1)'(DEPTH);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = state == ISSUE;
  assign start_job     = state == IDLE && count != '0;
  assign capture       = state == WAIT && cnt != '0 && bus.gcd_done;
  assign expire        = state == WAIT && !capture && cnt == CW'(TIMEOUT - 1);
  assign release_out   = state == HOLD && bus.out_ready;
  assign bus.gcd_start = pop;
  assign bus.busy      = state != IDLE || count != '0;
  always_comb state_n = start_job ? ISSUE : pop ? WAIT : (capture || expire) ? HOLD : release_out ? IDLE : state;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (push) begin
      mem_a[wr_ptr]   <= bus.in_a;
      mem_b[wr_ptr]   <= bus.in_b;
      mem_tag[wr_ptr] <= push_tag;
    end
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      push_tag       <= '0;
      cur_tag        <= '0;
      cnt            <= '0;
      bus.gcd_a      <= '0;
      bus.gcd_b      <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_tag    <= '0;
      bus.out_err    <= 1'b0;
    end else begin
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      cnt   <= state == WAIT ? cnt + CW'(1) : '0;
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        push_tag <= push_tag + 4'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (start_job) begin
        bus.gcd_a <= mem_a[rd_ptr];
        bus.gcd_b <= mem_b[rd_ptr];
        cur_tag   <= mem_tag[rd_ptr];
      end
      if (capture || expire) begin
        bus.out_valid  <= 1'b1;
        bus.out_result <= capture ? bus.gcd_result : '0;
        bus.out_tag    <= cur_tag;
        bus.out_err    <= !capture;
      end
      if (release_out) bus.out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_gcd_dispatch.sv
// tb_gcd_dispatch: scoreboard bench for gcd_dispatch with a behavioural gcd core
module tb_gcd_dispatch;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  gcd_dispatch_if #(.WIDTH(W)) bus();
  gcd_dispatch #(.WIDTH(W), .DEPTH(4), .TIMEOUT(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   tag;
    logic         err;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  logic [3:0] tb_tag = '0;
  int core_delay = 0;
  bit hang_mode = 0;
  bit stale_mode = 0;
  logic [W-1:0] core_res;
  int core_ctr = 0;
  bit core_busy = 0;
  int start_cnt = 0;
  int n_done = 0;
  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x = a;
    logic [W-1:0] y = b;
    logic [W-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction
  always @(posedge clk)
    if (reset) begin
      bus.gcd_done   <= 1'b0;
      bus.gcd_result <= '0;
      core_busy      <= 0;
      core_ctr       <= 0;
    end else if (bus.gcd_start) begin
      core_busy <= 1;
      core_ctr  <= 0;
      core_res  <= gcd_ref(bus.gcd_a, bus.gcd_b);
      if (!stale_mode) bus.gcd_done <= 1'b0;
    end else if (core_busy && !hang_mode) begin
      if (core_ctr == core_delay) begin
        bus.gcd_done   <= 1'b1;
        bus.gcd_result <= core_res;
        core_busy      <= 0;
      end else begin
        if (core_ctr == 0) bus.gcd_done <= 1'b0;
        core_ctr <= core_ctr + 1;
      end
    end
  always @(posedge clk)
    if (reset) start_cnt <= 0;
    else if (bus.gcd_start) start_cnt <= start_cnt + 1;
  always @(negedge clk)
    if (reset) n_done = 0;
    else if (bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected got result=%0d tag=%0d err=%0b required no output", bus.out_result, bus.out_tag, bus.out_err);
      end else begin
        mon_e = sb.pop_front();
        if ({bus.out_result, bus.out_tag, bus.out_err} !== mon_e) begin
          failures++;
          $display("FAIL out_data got result=%0d tag=%0d err=%0b required result=%0d tag=%0d err=%0b",
                   bus.out_result, bus.out_tag, bus.out_err, mon_e.res, mon_e.tag, mon_e.err);
        end
      end
      n_done++;
      checks++;
      if (start_cnt !== n_done) begin
        failures++;
        $display("FAIL start_per_job got starts=%0d required=%0d", start_cnt, n_done);
      end
    end
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    sb.delete();
    tb_tag = '0;
  endtask
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL push_accept got in_ready=%0b required=1", bus.in_ready);
    end
    e.res = hang_mode ? '0 : gcd_ref(a, b);
    e.tag = tb_tag;
    e.err = hang_mode;
    sb.push_back(e);
    tb_tag++;
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((bus.busy || bus.out_valid || sb.size() != 0) && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 1000) begin
      failures++;
      $display("FAIL drain got busy=%0b pending=%0d required idle", bus.busy, sb.size());
    end
  endtask
  task automatic wait_start(input string name);
    int n = 0;
    while (bus.gcd_start !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (bus.gcd_start !== 1'b1) begin
      failures++;
      $display("FAIL %s_start got gcd_start=%0b required=1", name, bus.gcd_start);
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %0b required 1", bus.in_ready); end
    checks++;
    if (bus.gcd_start !== 1'b0) begin failures++; $display("FAIL reset_gcd_start got %0b required 0", bus.gcd_start); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %0b required 0", bus.busy); end
    checks++;
    if ({bus.gcd_a, bus.gcd_b} !== '0) begin failures++; $display("FAIL reset_operands got a=%0d b=%0d required 0", bus.gcd_a, bus.gcd_b); end
    checks++;
    if ({bus.out_valid, bus.out_result, bus.out_tag, bus.out_err} !== '0) begin
      failures++;
      $display("FAIL reset_out got valid=%0b result=%0d tag=%0d err=%0b required all 0", bus.out_valid, bus.out_result, bus.out_tag, bus.out_err);
    end
  endtask
  task automatic test_single();
    do_reset();
    bus.out_ready = 1'b1;
    core_delay = 1;
    push(48, 18);
    checks++;
    if (bus.gcd_start !== 1'b0) begin failures++; $display("FAIL single_early_start got %0b required 0", bus.gcd_start); end
    tick();
    checks++;
    if (bus.gcd_start !== 1'b1) begin failures++; $display("FAIL single_start_cycle2 got %0b required 1", bus.gcd_start); end
    checks++;
    if ({bus.gcd_a, bus.gcd_b} !== {32'd48, 32'd18}) begin failures++; $display("FAIL single_operands got a=%0d b=%0d required a=48 b=18", bus.gcd_a, bus.gcd_b); end
    tick();
    checks++;
    if (bus.gcd_start !== 1'b0) begin failures++; $display("FAIL single_pulse_width got %0b required 0", bus.gcd_start); end
    drain();
    checks++;
    if (start_cnt !== 1) begin failures++; $display("FAIL single_start_count got %0d required 1", start_cnt); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    bus.out_ready = 1'b1;
    core_delay = 0;
    push(7, 13);
    push(0, 5);
    push(0, 0);
    drain();
    checks++;
    if (start_cnt !== 3) begin failures++; $display("FAIL b2b_start_count got %0d required 3", start_cnt); end
  endtask
  task automatic test_full();
    exp_t e;
    do_reset();
    bus.out_ready = 1'b1;
    core_delay = 8;
    push(12, 8);
    wait_start("full_first");
    tick();
    push(100, 75);
    push(9, 6);
    push(17, 5);
    push(81, 27);
    bus.in_valid = 1'b1;
    bus.in_a = 1000;
    bus.in_b = 250;
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL full_5th_ready got %0b required 0", bus.in_ready); end
    wait_start("full_pop");
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL full_issue_ready got %0b required 0", bus.in_ready); end
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL full_after_pop_ready got %0b required 1", bus.in_ready); end
    e.res = gcd_ref(1000, 250);
    e.tag = tb_tag;
    e.err = 1'b0;
    sb.push_back(e);
    tb_tag++;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL full_refilled_ready got %0b required 0", bus.in_ready); end
    drain();
    checks++;
    if (start_cnt !== 6) begin failures++; $display("FAIL full_start_count got %0d required 6", start_cnt); end
  endtask
  task automatic test_hold();
    int n = 0;
    int s;
    logic [W-1:0] r;
    logic [3:0] t;
    logic e;
    do_reset();
    core_delay = 2;
    bus.out_ready = 1'b0;
    push(21, 14);
    push(30, 12);
    while (!bus.out_valid && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if ({bus.out_valid, bus.out_result, bus.out_tag, bus.out_err} !== {1'b1, 32'd7, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL hold_first got valid=%0b result=%0d tag=%0d err=%0b required valid=1 result=7 tag=0 err=0", bus.out_valid, bus.out_result, bus.out_tag, bus.out_err);
    end
    r = bus.out_result;
    t = bus.out_tag;
    e = bus.out_err;
    s = start_cnt;
    repeat (10) begin
      tick();
      checks++;
      if ({bus.out_valid, bus.out_result, bus.out_tag, bus.out_err, start_cnt} !== {1'b1, r, t, e, s}) begin
        failures++;
        $display("FAIL hold_stable got valid=%0b result=%0d tag=%0d starts=%0d required valid=1 result=%0d tag=%0d starts=%0d",
                 bus.out_valid, bus.out_result, bus.out_tag, start_cnt, r, t, s);
      end
    end
    bus.out_ready = 1'b1;
    wait_start("hold_release");
    drain();
  endtask
  task automatic test_stale();
    do_reset();
    bus.out_ready = 1'b1;
    core_delay = 0;
    push(40, 30);
    drain();
    stale_mode = 1;
    core_delay = 3;
    push(27, 18);
    drain();
    stale_mode = 0;
    checks++;
    if (start_cnt !== 2) begin failures++; $display("FAIL stale_start_count got %0d required 2", start_cnt); end
  endtask
  task automatic test_timeout();
    int n = 0;
    bit seen = 0;
    do_reset();
    bus.out_ready = 1'b1;
    hang_mode = 1;
    push(5, 10);
    wait_start("timeout");
    tick();
    while (!bus.out_valid && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 16) begin failures++; $display("FAIL timeout_wait_cycles got %0d required 16", n); end
    checks++;
    if ({bus.out_valid, bus.out_result, bus.out_err} !== {1'b1, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL timeout_out got valid=%0b result=%0d err=%0b required valid=1 result=0 err=1", bus.out_valid, bus.out_result, bus.out_err);
    end
    tick();
    push(6, 4);
    wait_start("midwait");
    tick();
    push(8, 2);
    push(9, 3);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.in_ready, bus.gcd_start, bus.out_valid, bus.out_err, bus.busy, bus.out_tag, bus.out_result, bus.gcd_a, bus.gcd_b} !== {5'b10000, 4'd0, 96'd0}) begin
      failures++;
      $display("FAIL midwait_reset got ready=%0b start=%0b valid=%0b err=%0b busy=%0b tag=%0d result=%0d a=%0d b=%0d required ready=1 rest 0",
               bus.in_ready, bus.gcd_start, bus.out_valid, bus.out_err, bus.busy, bus.out_tag, bus.out_result, bus.gcd_a, bus.gcd_b);
    end
    reset = 1'b0;
    sb.delete();
    tb_tag = '0;
    hang_mode = 0;
    repeat (20) begin
      tick();
      if (bus.out_valid || bus.gcd_start || bus.busy) seen = 1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL midwait_discard got activity=1 required 0"); end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_hold();
    test_stale();
    test_timeout();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got %0d required 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gcd_dispatch.md
GCD_DISPATCH -- requirements
Module: gcd_dispatch

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter DEPTH, default 4, job FIFO entries; SHALL be a power of 2, at least 2.
REQ-003 Parameter TIMEOUT, default 1024, maximum cycles to wait for gcd_done.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  upstream job {in_a,in_b} present.
REQ-007 in_a, in_b  in  WIDTH each  job operands.
REQ-008 in_ready  out  1  job FIFO can accept a job.
REQ-009 gcd_start  out  1  one-cycle start pulse to the gcd core.
REQ-010 gcd_a, gcd_b  out  WIDTH each  registered operands to the core.
REQ-011 gcd_result  in  WIDTH  core result.
REQ-012 gcd_done  in  1  core completion level.
REQ-013 out_valid  out  1  result held for downstream.
REQ-014 out_ready  in  1  downstream accepts the result.
REQ-015 out_result  out  WIDTH  captured GCD value.
REQ-016 out_tag  out  4  sequence number of the job.
REQ-017 out_err  out  1  job ended by timeout.
REQ-018 busy  out  1  FSM not IDLE, or FIFO not empty.

Function
REQ-019 Push SHALL occur when in_valid && in_ready; in_ready SHALL be !full, from registered count only, with no same-cycle bypass.
REQ-020 Each push SHALL store {in_a, in_b, tag}; tag starts at 0 and increments per push, wrapping 15->0.
REQ-021 FSM states: IDLE, ISSUE, WAIT, HOLD.
REQ-022 IDLE->ISSUE when the FIFO is non-empty; otherwise remain in IDLE.
REQ-023 ISSUE actions, all within one cycle: gcd_start=1; head entry popped; head operands already on gcd_a/gcd_b; transition to WAIT.
REQ-024 Timing from a push into an empty FIFO in IDLE: gcd_start high in the 2nd cycle after the push edge.
REQ-025 gcd_a/gcd_b SHALL load at the IDLE->ISSUE edge and hold stable until the next ISSUE.
REQ-026 gcd_done SHALL be ignored during ISSUE and during the first WAIT cycle, to reject a stale done level from the previous job.
REQ-027 WAIT capture: from the second WAIT cycle on, the first cycle with gcd_done=1 loads out_result=gcd_result, out_tag, out_err=0, out_valid=1 -> HOLD.
REQ-028 WAIT timeout: a cycle counter cleared on entry to WAIT; reaching TIMEOUT without capture loads out_result=0, out_err=1, out_valid=1 -> HOLD.
REQ-029 HOLD: out_* SHALL remain stable while out_ready=0; out_valid && out_ready -> out_valid=0, next state IDLE.
REQ-030 Simultaneous push and ISSUE pop SHALL both complete; count unchanged; FIFO pointers wrap modulo DEPTH.
REQ-031 Pushes SHALL continue in any FSM state while not full.
REQ-032 Jobs SHALL complete strictly in FIFO order; at most one job SHALL be outstanding at the core.

Reset
REQ-033 Reset values: FSM=IDLE, FIFO empty, push tag=0, timeout counter=0, gcd_start=0, gcd_a=gcd_b=0, out_valid=0, out_result=0, out_tag=0, out_err=0, busy=0, in_ready=1.
REQ-034 Reset asserted in any state, including mid-WAIT or HOLD, SHALL discard all queued and in-flight jobs with no output produced.

Verification
REQ-035 Push (48,18) with out_ready=1 -> exactly one gcd_start pulse; result 6, tag 0, out_err=0.
REQ-036 Back-to-back pushes (7,13), (0,5), (0,0) -> results 1, 5, 0 in order with tags 0, 1, 2; each has exactly one gcd_start.
REQ-037 FSM in WAIT, DEPTH=4 -> 4 pushes accepted; in_ready=0 on the 5th; that job is accepted the cycle after the next ISSUE pop.
REQ-038 out_ready=0 for 10 cycles in HOLD -> out_* stable and no new gcd_start; release -> next job issues.
REQ-039 Core model holding gcd_done=1 from a prior job, then delaying 3 cycles -> stale done ignored; the correct new result is captured.
REQ-040 Core model never raises done, TIMEOUT=16 -> out_valid after 16 WAIT cycles with out_err=1, out_result=0; reset pulsed mid-WAIT -> all outputs at REQ-033 values the next cycle.
